scm_stream_reader: RTL and testbench
====================================

SCM_STREAM_READER -- requirements
Module: scm_stream_reader

Interface
REQ-001: Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002: Parameter DATA_WIDTH, default 32, register-file word width.
REQ-003: Parameter LEN_WIDTH, default 6, burst length field width.
REQ-004: clk  input  1  clock, all state updates on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous, active-low.
REQ-006: cmd_valid_i  input  1  burst command valid.
REQ-007: cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-008: cmd_addr_i  input  ADDR_WIDTH  burst start address.
REQ-009: cmd_len_i  input  LEN_WIDTH  burst length in words.
REQ-010: rf_ren_o  output  1  read enable to 1R1W register file.
REQ-011: rf_raddr_o  output  ADDR_WIDTH  read address to register file.
REQ-012: rf_rdata_i  input  DATA_WIDTH  register-file read data, valid the cycle after rf_ren_o.
REQ-013: out_valid_o  output  1  stream data valid.
REQ-014: out_ready_i  input  1  stream sink ready.
REQ-015: out_data_o  output  DATA_WIDTH  stream data.
REQ-016: busy_o  output  1  burst in progress or words still buffered.
REQ-017: done_o  output  1  one-cycle pulse after the last burst word is transferred.

Function
REQ-018: States IDLE, ISSUE, DRAIN; IDLE->ISSUE on command accept with len>0; ISSUE->DRAIN after the last read is issued; DRAIN->IDLE when buffer empty and no read in flight.
REQ-019: cmd_ready_o SHALL be high only in IDLE.
REQ-020: A command with cmd_len_i=0 SHALL be accepted, issue no reads, stay in IDLE, and pulse done_o the following cycle.
REQ-021: The first rf_ren_o SHALL be asserted the cycle after acceptance, at rf_raddr_o=cmd_addr_i.
REQ-022: Successive reads SHALL use address+1 modulo 2**ADDR_WIDTH (wrap from all-ones to 0).
REQ-023: rf_rdata_i SHALL be captured into a 2-entry output FIFO at the edge ending the cycle after each rf_ren_o.
REQ-024: rf_ren_o SHALL be asserted only if FIFO occupancy plus in-flight reads is below 2; no word is ever dropped or duplicated.
REQ-025: With out_ready_i held high, throughput SHALL be one word per cycle; first out_valid_o 2 cycles after first rf_ren_o.
REQ-026: out_valid_o/out_data_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-027: Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-028: Words SHALL be emitted in address order.
REQ-029: done_o SHALL pulse the cycle after the transfer of the last word; busy_o high from acceptance until that pulse.
REQ-030: rf_raddr_o SHALL hold its last value when rf_ren_o is low.

Reset
REQ-031: On rst_n low: state IDLE, FIFO empty, no read in flight, rf_ren_o=0, rf_raddr_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, cmd_ready_o=1 after release.
REQ-032: Reset mid-burst SHALL abort the burst, discard buffered words and no done_o pulse is generated.

Configuration
REQ-033: Macro SCM_STREAM_READER_LAST_EN defined: output out_last_o (1 bit) SHALL be high with the final word of each burst; undefined: port absent, behaviour otherwise identical.

Verification
REQ-034: Preload words 0..31 = 0x100+addr; cmd addr=4 len=8, out_ready_i=1 -> 8 words 0x104..0x10B on consecutive cycles, done_o pulses once.
REQ-035: cmd addr=30 len=4 -> data from addresses 30,31,0,1 in that order.
REQ-036: len=8, out_ready_i toggled 1/0 every cycle -> no loss or duplication, data stable when stalled, rf_ren_o never exceeds 2 outstanding plus buffered.
REQ-037: cmd len=0 -> cmd accepted, rf_ren_o stays 0, done_o pulses next cycle, out_valid_o stays 0.
REQ-038: rst_n asserted after 3 of 8 words -> all outputs at reset values, next command addr=0 len=2 returns 0x100, 0x101.
REQ-039: cmd_valid_i held high during burst -> cmd_ready_o=0 until IDLE, second command starts only after done_o.

Source files
------------

// File: rtl/scm_stream_reader_if.sv
// Command, register-file and output-stream bundle for scm_stream_reader.
// SCM_STREAM_READER_LAST_EN adds out_last_o.
interface scm_stream_reader_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [LEN_WIDTH-1:0]  cmd_len_i;
    logic                  rf_ren_o;
    logic [ADDR_WIDTH-1:0] rf_raddr_o;
    logic [DATA_WIDTH-1:0] rf_rdata_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  busy_o;
    logic                  done_o;
`ifdef SCM_STREAM_READER_LAST_EN
    logic                  out_last_o;

    // master: command issuer, register file and stream sink
    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, rf_rdata_i, out_ready_i,
        input  cmd_ready_o, rf_ren_o, rf_raddr_o, out_valid_o, out_data_o,
               busy_o, done_o, out_last_o
    );
    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, rf_rdata_i, out_ready_i,
        output cmd_ready_o, rf_ren_o, rf_raddr_o, out_valid_o, out_data_o,
               busy_o, done_o, out_last_o
    );
`else
    modport master (
        output cmd_valid_i, cmd_addr_i, cmd_len_i, rf_rdata_i, out_ready_i,
        input  cmd_ready_o, rf_ren_o, rf_raddr_o, out_valid_o, out_data_o,
               busy_o, done_o
    );
    modport slave (
        input  cmd_valid_i, cmd_addr_i, cmd_len_i, rf_rdata_i, out_ready_i,
        output cmd_ready_o, rf_ren_o, rf_raddr_o, out_valid_o, out_data_o,
               busy_o, done_o
    );
`endif
endinterface

// File: rtl/scm_stream_reader.sv
// Burst reader: streams consecutive register-file words through a 2-entry FIFO.
// Define SCM_STREAM_READER_LAST_EN to drive out_last_o on the final word of a burst.
module scm_stream_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
) (
    input logic              clk,
    input logic              rst_n,
    scm_stream_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                      state, state_nx;
    logic                        accept, ren, push, pop, inflight, done;
    logic [1:0]                  occ;
    logic [2:0]                  budget;
    logic                        wptr, rptr;
    logic [1:0][DATA_WIDTH-1:0]  mem;
    logic [LEN_WIDTH-1:0]        issue_left, pop_left;
    logic [ADDR_WIDTH-1:0]       next_addr, last_addr;

    assign accept = bus.cmd_valid_i && (state == IDLE);
    assign pop    = (occ != 2'd0) && bus.out_ready_i;
    assign push   = inflight;

    // Slots claimed after this cycle's pop; a read issued now lands once
    // that pop has freed its entry, so streaming keeps one word per cycle.
    assign budget = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign ren    = (state == ISSUE) && (budget < 3'd2);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && bus.cmd_len_i != '0) state_nx = ISSUE;
            ISSUE:   if (ren && issue_left == LEN_WIDTH'(1)) state_nx = DRAIN;
            DRAIN:   if (occ == 2'd0 && !inflight) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Address generation; last_addr keeps the bus steady between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_addr  <= '0;
            last_addr  <= '0;
            issue_left <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= ren;
            if (accept) begin
                next_addr  <= bus.cmd_addr_i;
                issue_left <= bus.cmd_len_i;
            end else if (ren) begin
                next_addr  <= next_addr + ADDR_WIDTH'(1);
                last_addr  <= next_addr;
                issue_left <= issue_left - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= bus.rf_rdata_i;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_left <= '0;
            done     <= 1'b0;
        end else begin
            done <= (accept && bus.cmd_len_i == '0) ||
                    (pop && pop_left == LEN_WIDTH'(1));
            if (accept)   pop_left <= bus.cmd_len_i;
            else if (pop) pop_left <= pop_left - LEN_WIDTH'(1);
        end
    end

    assign bus.cmd_ready_o = (state == IDLE);
    assign bus.rf_ren_o    = ren;
    assign bus.rf_raddr_o  = ren ? next_addr : last_addr;
    assign bus.out_valid_o = (occ != 2'd0);
    assign bus.out_data_o  = mem[rptr];
    assign bus.busy_o      = (state != IDLE);
    assign bus.done_o      = done;
`ifdef SCM_STREAM_READER_LAST_EN
    assign bus.out_last_o  = (occ != 2'd0) && (pop_left == LEN_WIDTH'(1));
`endif
endmodule

// File: tb/tb_scm_stream_reader.sv
// Directed bench for scm_stream_reader: burst-level model compared every cycle
// plus literal expectations for each scenario.
module tb_scm_stream_reader;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scm_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();
    scm_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [DW-1:0] rf [32];
    logic [DW-1:0] rdata_q = '0;
    always @(posedge clk) if (bus.rf_ren_o) rdata_q <= rf[bus.rf_raddr_o];
    assign bus.rf_rdata_i = rdata_q;

    int errs = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Burst-level model: the words a burst must deliver, and how far it has got.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] recv[$];
    int            recv_cyc[$];
    int            done_cyc[$];
    int            acc_cyc[$];
    logic [AW-1:0] base_m, last_addr_m, exp_a;
    logic [DW-1:0] stall_data;
    int  len_m = 0, issued_m = 0, popped_m = 0, done_cnt = 0;
    int  first_ren_cyc = -1, first_val_cyc = -1;
    bit  busy_m = 0, done_exp = 0, done_next = 0, stall_prev = 0, pop_now;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ren", bus.rf_ren_o, 0);
            chk("rst_raddr", bus.rf_raddr_o, 0);
            chk("rst_valid", bus.out_valid_o, 0);
            chk("rst_data", bus.out_data_o, 0);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_done", bus.done_o, 0);
            exp_q.delete();
            busy_m = 0; done_exp = 0; stall_prev = 0;
            last_addr_m = '0; len_m = 0; issued_m = 0; popped_m = 0;
        end else begin
            done_next = 0;
            pop_now   = bus.out_valid_o && bus.out_ready_i;
            chk("done", bus.done_o, done_exp);
            chk("busy", bus.busy_o, busy_m);
            chk("cmd_ready", bus.cmd_ready_o, !busy_m);
            if (bus.done_o) begin done_cnt++; done_cyc.push_back(cyc); end
            if (stall_prev) begin
                chk("stall_valid", bus.out_valid_o, 1);
                chk("stall_data", bus.out_data_o, stall_data);
            end
            if (bus.rf_ren_o) begin
                exp_a = base_m + AW'(issued_m);
                chk("raddr", bus.rf_raddr_o, exp_a);
                chk("ren_within_len", issued_m < len_m, 1);
                chk("ren_outstanding", (issued_m - popped_m - int'(pop_now)) < 2, 1);
                if (first_ren_cyc < 0) first_ren_cyc = cyc;
                last_addr_m = exp_a;
                issued_m++;
            end else begin
                chk("raddr_hold", bus.rf_raddr_o, last_addr_m);
            end
            if (bus.out_valid_o) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (exp_q.size() == 0) chk("spurious_valid", bus.out_valid_o, 0);
                else begin
                    chk("data", bus.out_data_o, exp_q[0]);
`ifdef SCM_STREAM_READER_LAST_EN
                    chk("last", bus.out_last_o, exp_q.size() == 1);
`endif
                    if (bus.out_ready_i) begin
                        recv.push_back(bus.out_data_o);
                        recv_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        popped_m++;
                        if (popped_m == len_m) done_next = 1;
                    end
                end
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
            stall_data = bus.out_data_o;
            if (done_exp) busy_m = 0;
            if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                acc_cyc.push_back(cyc);
                base_m = bus.cmd_addr_i;
                len_m = int'(bus.cmd_len_i);
                issued_m = 0; popped_m = 0;
                for (int i = 0; i < len_m; i++) exp_q.push_back(rf[(int'(bus.cmd_addr_i) + i) % 32]);
                if (len_m == 0) done_next = 1;
                else busy_m = 1;
            end
            done_exp = done_next;
        end
    end

    task automatic clear_logs();
        recv.delete(); recv_cyc.delete(); done_cyc.delete(); acc_cyc.delete();
        first_ren_cyc = -1; first_val_cyc = -1;
    endtask

    task automatic run_burst(input int addr, input int len, input bit tog, input int bound);
        int  d0;
        bit  sent;
        d0 = done_cnt; sent = 0;
        bus.cmd_addr_i = AW'(addr); bus.cmd_len_i = LW'(len); bus.cmd_valid_i = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.cmd_valid_i && bus.cmd_ready_o) sent = 1;
            @(posedge clk); #1;
            if (sent) bus.cmd_valid_i = 1'b0;
            if (tog) bus.out_ready_i = ~bus.out_ready_i;
            if (done_cnt > d0) break;
        end
        chk("burst_finished", done_cnt > d0, 1);
        bus.cmd_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_w;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_len_i = '0;
        bus.out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", bus.cmd_ready_o, 1);

        // 8 words from address 4 at full rate
        clear_logs();
        run_burst(4, 8, 0, 100);
        chk("t1_count", recv.size(), 8);
        for (int i = 0; i < 8 && i < recv.size(); i++) begin
            exp_w = 32'h104 + i;
            chk("t1_word", recv[i], exp_w);
        end
        if (recv_cyc.size() == 8) chk("t1_back_to_back", recv_cyc[7] - recv_cyc[0], 7);
        chk("t1_ren_after_accept", first_ren_cyc - acc_cyc[0], 1);
        chk("t1_first_valid_latency", first_val_cyc - first_ren_cyc, 2);
        chk("t1_done_pulses", done_cyc.size(), 1);

        // address wrap
        clear_logs();
        run_burst(30, 4, 0, 100);
        chk("t2_count", recv.size(), 4);
        if (recv.size() == 4) begin
            chk("t2_w0", recv[0], 32'h11E);
            chk("t2_w1", recv[1], 32'h11F);
            chk("t2_w2", recv[2], 32'h100);
            chk("t2_w3", recv[3], 32'h101);
        end

        // sink ready toggling every cycle
        clear_logs();
        bus.out_ready_i = 1'b0;
        run_burst(12, 8, 1, 200);
        chk("t3_count", recv.size(), 8);
        for (int i = 0; i < 8 && i < recv.size(); i++) begin
            exp_w = 32'h10C + i;
            chk("t3_word", recv[i], exp_w);
        end

        // zero-length command
        clear_logs();
        run_burst(7, 0, 0, 20);
        chk("t4_no_reads", first_ren_cyc, -1);
        chk("t4_no_valid", first_val_cyc, -1);
        if (done_cyc.size() > 0) chk("t4_done_next_cycle", done_cyc[0] - acc_cyc[0], 1);

        // reset after 3 of 8 words
        clear_logs();
        bus.cmd_addr_i = 5'd10; bus.cmd_len_i = 6'd8; bus.cmd_valid_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (acc_cyc.size() > 0) bus.cmd_valid_i = 1'b0;
            if (recv.size() >= 3) break;
        end
        chk("t5_words_before_reset", recv.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", bus.out_valid_o, 0);
        chk("t5_async_busy", bus.busy_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t5_no_done_after_reset", done_cyc.size(), 0);
        clear_logs();
        run_burst(0, 2, 0, 50);
        chk("t5_count", recv.size(), 2);
        if (recv.size() == 2) begin
            chk("t5_w0", recv[0], 32'h100);
            chk("t5_w1", recv[1], 32'h101);
        end

        // command held valid across a burst
        clear_logs();
        bus.cmd_addr_i = 5'd8; bus.cmd_len_i = 6'd3; bus.cmd_valid_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            @(posedge clk); #1;
            if (acc_cyc.size() == 1) begin bus.cmd_addr_i = 5'd16; bus.cmd_len_i = 6'd2; end
            if (acc_cyc.size() == 2) bus.cmd_valid_i = 1'b0;
            if (done_cyc.size() >= 2) break;
        end
        bus.cmd_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        chk("t6_two_accepts", acc_cyc.size(), 2);
        chk("t6_two_dones", done_cyc.size(), 2);
        if (acc_cyc.size() == 2 && done_cyc.size() >= 1)
            chk("t6_second_after_done", acc_cyc[1] > done_cyc[0], 1);
        chk("t6_count", recv.size(), 5);
        if (recv.size() == 5) begin
            chk("t6_w0", recv[0], 32'h108);
            chk("t6_w2", recv[2], 32'h10A);
            chk("t6_w3", recv[3], 32'h110);
            chk("t6_w4", recv[4], 32'h111);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
